// File: rtl/nba_permute_pkg.sv
// Shared definitions for the NBA permute engine: opcodes, FSM states and
// helpers for the packed {d,c,b,a} register layout.
package nba_permute_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SWAP  = 3'd2,
        OP_CHAIN = 3'd3,
        OP_ROT_L = 3'd4,
        OP_ROT_R = 3'd5,
        OP_FIB   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Helpers work on a lane size large enough for any sensible WIDTH;
    // callers cast their narrower values in and out.
    localparam int unsigned LANE_MAX = 64;
    localparam int unsigned BUS_MAX  = 4 * LANE_MAX;

    // Opcodes whose repeat count is meaningless always run a single step.
    function automatic logic is_single_step(input op_e op);
        return (op == OP_NOP) || (op == OP_LOAD) || (op == OP_CLEAR);
    endfunction

    function automatic logic [LANE_MAX-1:0] unpack_lane(
        input logic [BUS_MAX-1:0] bus,
        input int unsigned        lane_w,
        input int unsigned        idx
    );
        return LANE_MAX'(bus >> (idx * lane_w));
    endfunction

    function automatic logic [BUS_MAX-1:0] pack_lanes(
        input logic [LANE_MAX-1:0] a,
        input logic [LANE_MAX-1:0] b,
        input logic [LANE_MAX-1:0] c,
        input logic [LANE_MAX-1:0] d,
        input int unsigned         lane_w
    );
        return (BUS_MAX'(d) << (3 * lane_w)) |
               (BUS_MAX'(c) << (2 * lane_w)) |
               (BUS_MAX'(b) << lane_w)       |
                BUS_MAX'(a);
    endfunction

endpackage

// File: rtl/nba_permute_alu.sv
// Combinational next-value function for the four-register bank. Every output
// is computed from the pre-edge inputs only.
module nba_permute_alu
    import nba_permute_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e                  op,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [WIDTH-1:0]     c_in,
    input  logic [WIDTH-1:0]     d_in,
    input  logic [4*WIDTH-1:0]   load_data,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic [WIDTH-1:0]     c_out,
    output logic [WIDTH-1:0]     d_out
);

    logic [WIDTH-1:0] load_lane [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
        assign load_lane[gi] = WIDTH'(unpack_lane(BUS_MAX'(load_data), WIDTH, gi));
    end

    always_comb begin
        a_out = a_in;
        b_out = b_in;
        c_out = c_in;
        d_out = d_in;
        case (op)
            OP_LOAD: begin
                a_out = load_lane[0];
                b_out = load_lane[1];
                c_out = load_lane[2];
                d_out = load_lane[3];
            end
            OP_SWAP: begin
                a_out = b_in;
                b_out = a_in;
            end
            OP_CHAIN: begin
                a_out = c_in;
                b_out = d_in;
                c_out = a_in;
                d_out = b_in;
            end
            OP_ROT_L: begin
                a_out = b_in;
                b_out = c_in;
                c_out = d_in;
                d_out = a_in;
            end
            OP_ROT_R: begin
                a_out = d_in;
                b_out = a_in;
                c_out = b_in;
                d_out = c_in;
            end
            OP_FIB: begin
                a_out = a_in + b_in;
                b_out = a_in;
            end
            OP_CLEAR: begin
                a_out = '0;
                b_out = '0;
                c_out = '0;
                d_out = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nba_permute_engine.sv
// Command-driven bank of four registers applying atomic permutation and
// Fibonacci steps, with repeat mode and a held valid/ready response.
module nba_permute_engine
    import nba_permute_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [3:0]         cmd_rep,
    input  logic [4*WIDTH-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [4*WIDTH-1:0] rsp_data,
    output logic [3:0]         rsp_steps,
    output logic [CNT_W-1:0]   op_count
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [4*WIDTH-1:0] load_q, load_d;
    logic [3:0]         rem_q, rem_d;
    logic [3:0]         tot_q, tot_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [4*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]         rsp_steps_q, rsp_steps_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [WIDTH-1:0]   a_nx, b_nx, c_nx, d_nx;
    op_e                cmd_op_e;
    logic [3:0]         reps;

    assign cmd_op_e = op_e'(cmd_op);

    nba_permute_alu #(.WIDTH(WIDTH)) u_alu (
        .op        (op_q),
        .a_in      (a_q),
        .b_in      (b_q),
        .c_in      (c_q),
        .d_in      (d_q),
        .load_data (load_q),
        .a_out     (a_nx),
        .b_out     (b_nx),
        .c_out     (c_nx),
        .d_out     (d_nx)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        load_d      = load_q;
        rem_d       = rem_q;
        tot_d       = tot_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_steps_d = rsp_steps_q;
        op_count_d  = op_count_q;
        reps        = 4'd1;

        if (!is_single_step(cmd_op_e) && (cmd_rep != 4'd0)) begin
            reps = cmd_rep;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_RUN;
                    op_d    = cmd_op_e;
                    load_d  = cmd_data;
                    rem_d   = reps;
                    tot_d   = reps;
                end
            end
            ST_RUN: begin
                a_d   = a_nx;
                b_d   = b_nx;
                c_d   = c_nx;
                d_d   = d_nx;
                rem_d = rem_q - 4'd1;
                // The snapshot is taken from the ALU outputs so it matches
                // the values the registers take on this same edge.
                if (rem_q == 4'd1) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (4*WIDTH)'(pack_lanes(LANE_MAX'(a_nx), LANE_MAX'(b_nx),
                                                        LANE_MAX'(c_nx), LANE_MAX'(d_nx),
                                                        WIDTH));
                    rsp_steps_d = tot_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            load_q      <= '0;
            rem_q       <= '0;
            tot_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_steps_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            load_q      <= load_d;
            rem_q       <= rem_d;
            tot_q       <= tot_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_steps_q <= rsp_steps_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_steps = rsp_steps_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_nba_permute_engine.sv
// Self-checking bench for nba_permute_engine: directed vector table, hold and
// reset-abort sequences, then random commands against an array-based model.
module tb_nba_permute_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [3:0]         cmd_rep;
    logic [4*WIDTH-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [4*WIDTH-1:0] rsp_data;
    logic [3:0]         rsp_steps;
    logic [CNT_W-1:0]   op_count;

    int n_vec = 0;
    int n_err = 0;

    nba_permute_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_steps (rsp_steps),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rep;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [3:0]  exp_steps;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model: four lanes, a..d = mr[0..3].
    logic [7:0] mr [4];
    int         m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int src_lane(input int op, input int i);
        case (op)
            2:       return (i < 2) ? 1 - i : i;
            3:       return (i + 2) % 4;
            4:       return (i + 1) % 4;
            5:       return (i + 3) % 4;
            default: return i;
        endcase
    endfunction

    task automatic model_cmd(input int op, input int rep, input logic [31:0] data,
                             output logic [31:0] exp_data, output int exp_steps);
        logic [7:0] old [4];
        exp_steps = (op == 0 || op == 1 || op == 7 || rep == 0) ? 1 : rep;
        for (int s = 0; s < exp_steps; s++) begin
            old = mr;
            for (int i = 0; i < 4; i++) begin
                case (op)
                    1:       mr[i] = data[8*i +: 8];
                    2, 3, 4, 5: mr[i] = old[src_lane(op, i)];
                    7:       mr[i] = 8'd0;
                    default: ;
                endcase
            end
            if (op == 6) begin
                mr[0] = 8'((int'(old[0]) + int'(old[1])) % 256);
                mr[1] = old[0];
            end
        end
        exp_data = {mr[3], mr[2], mr[1], mr[0]};
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] rep, input logic [31:0] data,
                           input int hold, output logic [31:0] rdata, output logic [3:0] rsteps,
                           output int lat);
        int guard;
        logic [CNT_W-1:0] cnt;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rep   = rep;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        cmd_op    = 3'($urandom);
        cmd_rep   = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata  = rsp_data;
        rsteps = rsp_steps;
        cnt    = op_count;
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_data", 64'(rsp_data), 64'(rdata));
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_op_count", 64'(op_count), 64'(cnt));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("op_count_inc", 64'(op_count), 64'(cnt + 1'b1));
        chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        $display("cmd op=%0d rep=%0d data=%08h -> rsp=%08h steps=%0d lat=%0d count=%0d",
                 op, rep, data, rdata, rsteps, lat, op_count);
    endtask

    initial begin
        logic [31:0] rdata, edata;
        logic [3:0]  rsteps;
        int          lat, esteps, seen;

        tbl[0]  = '{3'd1, 4'd0,  {8'd40, 8'd30, 8'd20, 8'd10}, {8'd40, 8'd30, 8'd20, 8'd10}, 4'd1};
        tbl[1]  = '{3'd2, 4'd1,  32'h0,                       {8'd40, 8'd30, 8'd10, 8'd20}, 4'd1};
        tbl[2]  = '{3'd3, 4'd1,  32'h0,                       {8'd10, 8'd20, 8'd40, 8'd30}, 4'd1};
        tbl[3]  = '{3'd1, 4'd7,  {8'd4, 8'd3, 8'd2, 8'd1},    {8'd4, 8'd3, 8'd2, 8'd1},     4'd1};
        tbl[4]  = '{3'd4, 4'd4,  32'h0,                       {8'd4, 8'd3, 8'd2, 8'd1},     4'd4};
        tbl[5]  = '{3'd5, 4'd0,  32'h0,                       {8'd3, 8'd2, 8'd1, 8'd4},     4'd1};
        tbl[6]  = '{3'd1, 4'd0,  {8'd0, 8'd0, 8'd0, 8'd1},    {8'd0, 8'd0, 8'd0, 8'd1},     4'd1};
        tbl[7]  = '{3'd6, 4'd13, 32'h0,                       {8'd0, 8'd0, 8'd233, 8'd121}, 4'd13};
        tbl[8]  = '{3'd0, 4'd5,  32'hdeadbeef,                {8'd0, 8'd0, 8'd233, 8'd121}, 4'd1};
        tbl[9]  = '{3'd7, 4'd3,  32'h0,                       32'h0,                        4'd1};
        tbl[10] = '{3'd1, 4'd9,  32'h11223344,                32'h11223344,                 4'd1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rep   = 4'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_steps", 64'(rsp_steps), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].op, tbl[i].rep, tbl[i].data, 0, rdata, rsteps, lat);
            chk($sformatf("tbl%0d_data", i), 64'(rdata), 64'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_steps", i), 64'(rsteps), 64'(tbl[i].exp_steps));
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_steps));
            chk($sformatf("tbl%0d_count", i), 64'(op_count), 64'(i + 1));
        end

        // Response held for five cycles with rsp_ready low.
        run_cmd(3'd4, 4'd1, 32'h0, 5, rdata, rsteps, lat);
        chk("hold_rot_data", 64'(rdata), 64'h44112233);
        chk("hold_count", 64'(op_count), 64'd12);

        // Reset in the middle of a long FIB run aborts it.
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_rep   = 4'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_op_count", 64'(op_count), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_response", 64'(seen), 64'd0);
        run_cmd(3'd0, 4'd0, 32'h0, 0, rdata, rsteps, lat);
        chk("abort_regs_cleared", 64'(rdata), 64'd0);
        chk("abort_count_restart", 64'(op_count), 64'd1);

        for (int i = 0; i < 4; i++) mr[i] = 8'd0;
        m_count = 1;
        for (int t = 0; t < 40; t++) begin
            int          op, rep;
            logic [31:0] data;
            op   = (t % 6 == 0) ? 1 : int'($urandom_range(0, 7));
            rep  = int'($urandom_range(0, 15));
            data = $urandom;
            model_cmd(op, rep, data, edata, esteps);
            m_count++;
            run_cmd(3'(op), 4'(rep), data, int'($urandom_range(0, 2)), rdata, rsteps, lat);
            chk($sformatf("rnd%0d_data", t), 64'(rdata), 64'(edata));
            chk($sformatf("rnd%0d_steps", t), 64'(rsteps), 64'(esteps));
            chk($sformatf("rnd%0d_latency", t), 64'(lat), 64'(esteps));
            chk($sformatf("rnd%0d_count", t), 64'(op_count), 64'(m_count));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
